// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing arbiter slice.
//   OP_ADD/OP_AND/OP_XOR/OP_SUB : 2-bit ALU opcodes
//   state_e                     : sequencer states (IDLE, EXEC, RESP)
//   STAT_W                      : width of the optional statistics counters
package alu_share_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD = 2'b00;
  localparam op_t OP_AND = 2'b01;
  localparam op_t OP_XOR = 2'b10;
  localparam op_t OP_SUB = 2'b11;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for alu_share_arbiter.
//   req_valid/req_ready : per-requester handshake (NUM_REQ bits each)
//   req_a/req_b         : operands, requester i at [i*DATA_W +: DATA_W]
//   req_op              : opcodes, requester i at [i*2 +: 2]
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/rsp_data/rsp_carry : tagged result
// master = requesters + consumer, slave = arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*2-1:0]      req_op;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_carry;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry
  );
endinterface

// File: rtl/alu_share_core.sv
// Purely combinational DATA_W-bit ALU shared by all requesters.
//   a_i, b_i : operands
//   op_i     : ADD / AND / XOR / SUB
//   data_o   : result (mod 2**DATA_W)
//   carry_o  : carry out for ADD, borrow for SUB, 0 for logic ops
module alu_share_core
  import alu_share_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  op_t               op_i,
  output logic [DATA_W-1:0] data_o,
  output logic              carry_o
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide    = '0;
    data_o  = '0;
    carry_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        wide    = {1'b0, a_i} + {1'b0, b_i};
        data_o  = wide[DATA_W-1:0];
        carry_o = wide[DATA_W];
      end
      OP_AND: data_o = a_i & b_i;
      OP_XOR: data_o = a_i ^ b_i;
      OP_SUB: begin
        // top bit of the zero-extended difference is the unsigned borrow
        wide    = {1'b0, a_i} - {1'b0, b_i};
        data_o  = wide[DATA_W-1:0];
        carry_o = wide[DATA_W];
      end
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU among NUM_REQ requesters.
// Grant in IDLE, compute in EXEC, hold tagged result in RESP until accepted.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   bus       : alu_share_arbiter_if.slave request/response bundle
//   busy      : high whenever not in IDLE
// Optional (macro ALU_SHARE_STATS_EN):
//   grant_cnt : saturating count of accepted requests
//   stall_cnt : saturating count of RESP cycles with rsp_ready low
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ID_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus,
  output logic                busy
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [STAT_W-1:0]   grant_cnt,
  output logic [STAT_W-1:0]   stall_cnt
`endif
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] a_q, b_q;
  op_t               op_q;
  logic [ID_W-1:0]   id_q;
  logic [DATA_W-1:0] data_q;
  logic              carry_q;
  logic [ID_W-1:0]   rsp_id_q;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   rr_next;
  logic              accept;
  logic [DATA_W-1:0] a_sel, b_sel;
  op_t               op_sel;
  logic [DATA_W-1:0] alu_data;
  logic              alu_carry;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : rr_pick
    int unsigned        idx;
    logic [NUM_REQ-1:0] vld_rot;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    vld_rot   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      vld_rot = bus.req_valid >> idx;
      if (!gnt_found && vld_rot[0]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  assign rr_next = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  assign a_sel  = DATA_W'(bus.req_a >> (32'(gnt_idx) * DATA_W));
  assign b_sel  = DATA_W'(bus.req_b >> (32'(gnt_idx) * DATA_W));
  assign op_sel = op_t'(bus.req_op >> (32'(gnt_idx) * 2));

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    accept        = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          accept        = 1'b1;
          bus.req_ready = NUM_REQ'(1) << gnt_idx;
          rr_ptr_d      = rr_next;
          state_d       = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      id_q     <= '0;
      data_q   <= '0;
      carry_q  <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        a_q  <= a_sel;
        b_q  <= b_sel;
        op_q <= op_sel;
        id_q <= gnt_idx;
      end
      if (state_q == EXEC) begin
        data_q   <= alu_data;
        carry_q  <= alu_carry;
        rsp_id_q <= id_q;
      end
    end
  end

  alu_share_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .data_o  (alu_data),
    .carry_o (alu_carry)
  );

  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_carry = carry_q;
  assign busy          = (state_q != IDLE);

`ifdef ALU_SHARE_STATS_EN
  logic [STAT_W-1:0] grant_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && grant_cnt_q != '1) grant_cnt_q <= grant_cnt_q + 1'b1;
      if (state_q == RESP && !bus.rsp_ready && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
